// File: rtl/wb_gnt_arb.sv
`default_nettype none
// ============================================================================
// Module   : wb_gnt_arb
// Brief    : Round-robin one-hot grant arbiter for the 5-channel WB mixer.
//            Optional ack watchdog enabled by defining WB_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wb_gnt_arb #(
    parameter int NCH     = 5,
    parameter int PTR_W   = 3,
    parameter int TIMEOUT = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [NCH-1:0]   req_i,
    input  logic             wbm_ack_i,
    input  logic             wbm_err_i,
    input  logic             wbm_rty_i,
    output logic [NCH-1:0]   gnt,
    output logic             arb_busy_o,
    output logic [PTR_W-1:0] arb_last_o,
    output logic             arb_tmo_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [PTR_W-1:0] c_last_rst = PTR_W'(NCH - 1);
    localparam logic [PTR_W:0]   c_nch      = (PTR_W + 1)'(NCH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [NCH-1:0]   r_gnt;
    logic [NCH-1:0]   w_gnt_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic [PTR_W-1:0] r_last;
    logic [PTR_W-1:0] w_last_nxt;

    logic [PTR_W-1:0] w_start;
    logic [NCH-1:0]   w_rot;
    logic [PTR_W-1:0] w_off;
    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_winner;
    logic             w_found;
    logic             w_owner_req;
    logic             w_expire;
    logic             w_exit;

    // Rotate requests so bit 0 is the channel right after the last winner;
    // the lowest set bit of the rotated vector is then the round-robin winner.
    assign w_start = (r_last >= c_last_rst) ? '0 : r_last + 1'b1;
    assign w_rot   = NCH'({req_i, req_i} >> w_start);

    always_comb begin
        w_found = |w_rot;
        w_off   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = PTR_W'(i);
            end
        end
    end

    assign w_sum    = {1'b0, w_start} + {1'b0, w_off};
    assign w_winner = (w_sum >= c_nch) ? PTR_W'(w_sum - c_nch) : w_sum[PTR_W-1:0];

    assign w_owner_req = |(req_i & r_gnt);
    assign w_exit      = !w_owner_req || wbm_err_i || wbm_rty_i || w_expire;

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [7:0] c_tmo_last = 8'(TIMEOUT - 1);

    logic [7:0] r_cnt;
    logic       r_tmo;

    // Expiry fires on the TIMEOUT-th consecutive ack-less owned cycle.
    assign w_expire = (r_state == ST_OWN) && !wbm_ack_i && (r_cnt == c_tmo_last);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_cnt <= '0;
            r_tmo <= 1'b0;
        end else begin
            r_tmo <= w_expire;
            if ((r_state == ST_OWN) && !wbm_ack_i) begin
                r_cnt <= r_cnt + 8'd1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign arb_tmo_o = r_tmo;
`else
    logic w_unused;

    assign w_expire  = 1'b0;
    assign arb_tmo_o = 1'b0;
    assign w_unused  = &{1'b0, wbm_ack_i, (TIMEOUT != 0)};
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_busy_nxt  = r_busy;
        w_last_nxt  = r_last;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_OWN;
                    w_gnt_nxt   = {{(NCH - 1){1'b0}}, 1'b1} << w_winner;
                    w_busy_nxt  = 1'b1;
                    w_last_nxt  = w_winner;
                end
            end
            ST_OWN: begin
                if (w_exit) begin
                    w_state_nxt = ST_GAP;
                    w_gnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                end
            end
            ST_GAP: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_last  <= c_last_rst;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_busy  <= w_busy_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign gnt        = r_gnt;
    assign arb_busy_o = r_busy;
    assign arb_last_o = r_last;

endmodule
`default_nettype wire
